// File: rtl/vec_ldst_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vec_ldst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 3;

  function automatic int beats_per_reg(input int vlen, input int data_width);
    return vlen / data_width;
  endfunction

endpackage

// File: rtl/vec_ldst_fifo.sv
// 3-entry synchronous FIFO for store read data; async clear on rst_n, exposes occupancy.
module vec_ldst_fifo
  import vec_ldst_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]   r_wptr;
  logic [1:0]   r_rptr;
  logic [1:0]   r_count;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // storage, pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/vec_ldst_seq.sv
// Vector load/store sequencer between issue logic, the VRF ld/st ports and memory.
// Define VEC_LDST_STALL_CNT_EN to build the saturating stall performance counters.
module vec_ldst_seq
  import vec_ldst_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH / 8,
  parameter int OFF_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [ADDR_WIDTH-1:0] req_vreg,
  input  logic [OFF_BITS-1:0]   req_off,
  input  logic [OFF_BITS:0]     req_beats,
  input  logic [DW_B-1:0]       req_be,
  input  logic                  mem_rd_valid,
  output logic                  mem_rd_ready,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DW_B-1:0]       mem_wr_be,
  output logic                  mem_wr_last,
  output logic [DW_B-1:0]       rf_ld_en,
  output logic [ADDR_WIDTH-1:0] rf_ld_addr,
  output logic [OFF_BITS-1:0]   rf_ld_off,
  output logic [DATA_WIDTH-1:0] rf_ld_data,
  input  logic                  rf_ld_stall,
  output logic [DW_B-1:0]       rf_st_en,
  output logic [ADDR_WIDTH-1:0] rf_st_addr,
  output logic [OFF_BITS-1:0]   rf_st_off,
  input  logic [DATA_WIDTH-1:0] rf_st_data,
  output logic                  done,
  output logic [31:0]           perf_ld_stall,
  output logic [31:0]           perf_st_stall
);

  localparam int CW = OFF_BITS + 1;
  localparam logic [OFF_BITS-1:0] LAST_OFF = OFF_BITS'(beats_per_reg(VLEN, DATA_WIDTH) - 1);

  state_e                r_state, w_state_nxt;
  logic [DW_B-1:0]       r_be;
  logic [CW-1:0]         r_beats, r_cnt, r_iss_cnt;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_ld_addr, r_st_addr;
  logic [OFF_BITS-1:0]   r_ld_off, r_st_off;
  logic [1:0]            w_fifo_cnt;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic [CW-1:0]         w_last_cnt;
  logic                  w_req_hs, w_ld_hs, w_issue, w_wr_valid, w_wr_last, w_wr_hs;

  assign w_req_hs   = (r_state == IDLE) && req_valid;
  assign w_ld_hs    = (r_state == LOAD) && mem_rd_valid && !rf_ld_stall;
  assign w_last_cnt = r_beats - CW'(1);
  // a read in flight already owns a FIFO slot, so it counts against the credit
  assign w_issue    = (r_state == STORE) && (r_iss_cnt < r_beats) &&
                      (({1'b0, w_fifo_cnt} + {2'b00, r_inflight}) < 3'(FIFO_DEPTH));
  assign w_wr_valid = (r_state == STORE) && (w_fifo_cnt != 2'd0);
  assign w_wr_last  = w_wr_valid && (r_cnt == w_last_cnt);
  assign w_wr_hs    = w_wr_valid && mem_wr_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_req_hs)               w_state_nxt = IDLE;
        else if (req_beats == '0)    w_state_nxt = FIN;
        else if (req_is_store)       w_state_nxt = STORE;
        else                         w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_ld_hs && (r_cnt == w_last_cnt)) w_state_nxt = FIN;
        else                                  w_state_nxt = LOAD;
      end
      STORE: begin
        if (w_wr_hs && w_wr_last) w_state_nxt = FIN;
        else                      w_state_nxt = STORE;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // request capture and beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_be       <= '0;
      r_beats    <= '0;
      r_cnt      <= '0;
      r_iss_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_req_hs) begin
        r_be      <= req_be;
        r_beats   <= req_beats;
        r_cnt     <= '0;
        r_iss_cnt <= '0;
      end else begin
        if (w_ld_hs || w_wr_hs) r_cnt <= r_cnt + CW'(1);
        if (w_issue)            r_iss_cnt <= r_iss_cnt + CW'(1);
      end
    end
  end

  // load and store-issue cursors; offset wraps into the next register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_addr <= '0;
      r_ld_off  <= '0;
      r_st_addr <= '0;
      r_st_off  <= '0;
    end else if (w_req_hs) begin
      r_ld_addr <= req_vreg;
      r_ld_off  <= req_off;
      r_st_addr <= req_vreg;
      r_st_off  <= req_off;
    end else begin
      if (w_ld_hs) begin
        if (r_ld_off == LAST_OFF) begin
          r_ld_off  <= '0;
          r_ld_addr <= r_ld_addr + ADDR_WIDTH'(1);
        end else begin
          r_ld_off  <= r_ld_off + OFF_BITS'(1);
        end
      end
      if (w_issue) begin
        if (r_st_off == LAST_OFF) begin
          r_st_off  <= '0;
          r_st_addr <= r_st_addr + ADDR_WIDTH'(1);
        end else begin
          r_st_off  <= r_st_off + OFF_BITS'(1);
        end
      end
    end
  end

  vec_ldst_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (rf_st_data),
    .i_pop   (w_wr_hs),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_cnt)
  );

  assign req_ready    = rst_n && (r_state == IDLE);
  assign mem_rd_ready = (r_state == LOAD) && !rf_ld_stall;
  assign rf_ld_en     = w_ld_hs ? r_be : '0;
  assign rf_ld_addr   = r_ld_addr;
  assign rf_ld_off    = r_ld_off;
  assign rf_ld_data   = (r_state == LOAD) ? mem_rd_data : '0;
  assign rf_st_en     = w_issue ? r_be : '0;
  assign rf_st_addr   = r_st_addr;
  assign rf_st_off    = r_st_off;
  assign mem_wr_valid = w_wr_valid;
  assign mem_wr_data  = w_wr_valid ? w_fifo_head : '0;
  assign mem_wr_be    = r_be;
  assign mem_wr_last  = w_wr_last;
  assign done         = (r_state == FIN);

`ifdef VEC_LDST_STALL_CNT_EN
  logic [31:0] r_perf_ld, r_perf_st;

  // saturating stall counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ld <= 32'd0;
      r_perf_st <= 32'd0;
    end else begin
      if ((r_state == LOAD) && mem_rd_valid && rf_ld_stall && (r_perf_ld != 32'hFFFF_FFFF))
        r_perf_ld <= r_perf_ld + 32'd1;
      if (w_wr_valid && !mem_wr_ready && (r_perf_st != 32'hFFFF_FFFF))
        r_perf_st <= r_perf_st + 32'd1;
    end
  end

  assign perf_ld_stall = r_perf_ld;
  assign perf_st_stall = r_perf_st;
`else
  assign perf_ld_stall = 32'd0;
  assign perf_st_stall = 32'd0;
`endif

endmodule

// File: tb/tb_vec_ldst_seq.sv
// Scoreboard bench for vec_ldst_seq: loads, stalls, stores with backpressure, zero-length and reset.
`timescale 1ns/1ps
module tb_vec_ldst_seq;

  localparam int BPR = 128 / 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [4:0]  req_vreg = 5'd0;
  logic [7:0]  req_off = 8'd0;
  logic [8:0]  req_beats = 9'd0;
  logic [7:0]  req_be = 8'd0;
  logic        mem_rd_valid = 1'b0, mem_rd_ready;
  logic [63:0] mem_rd_data = 64'd0;
  logic        mem_wr_valid, mem_wr_ready = 1'b1, mem_wr_last;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_be, rf_ld_en, rf_st_en;
  logic [4:0]  rf_ld_addr, rf_st_addr;
  logic [7:0]  rf_ld_off, rf_st_off;
  logic [63:0] rf_ld_data;
  logic        rf_ld_stall = 1'b0;
  logic [63:0] rf_st_data = 64'd0;
  logic        done;
  logic [31:0] perf_ld_stall, perf_st_stall;

  always #5 clk = ~clk;

  vec_ldst_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_vreg(req_vreg), .req_off(req_off), .req_beats(req_beats), .req_be(req_be),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_last(mem_wr_last),
    .rf_ld_en(rf_ld_en), .rf_ld_addr(rf_ld_addr), .rf_ld_off(rf_ld_off),
    .rf_ld_data(rf_ld_data), .rf_ld_stall(rf_ld_stall),
    .rf_st_en(rf_st_en), .rf_st_addr(rf_st_addr), .rf_st_off(rf_st_off),
    .rf_st_data(rf_st_data), .done(done),
    .perf_ld_stall(perf_ld_stall), .perf_st_stall(perf_st_stall)
  );

  typedef struct {
    logic [4:0]  a;
    logic [7:0]  o;
    logic [63:0] d;
    bit          last;
    int          cyc;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ld_start = 0;
  logic [31:0] stall_mask = 32'd0;
  logic [31:0] wrblk_mask = 32'd0;
  logic [63:0] ld_q[$];
  bit          ld_hs_s = 1'b0, st_iss_s = 1'b0;
  logic [4:0]  iss_a_s = 5'd0;
  logic [7:0]  iss_o_s = 8'd0;

  function automatic logic [63:0] rf_model(input logic [4:0] a, input logic [7:0] o);
    return {16'hD00D, 11'd0, a, 24'd0, o};
  endfunction

  task automatic adv(inout logic [4:0] a, inout logic [7:0] o);
    if (o == 8'(BPR - 1)) begin
      o = 8'd0;
      a = a + 5'd1;
    end else begin
      o = o + 8'd1;
    end
  endtask

  // one clock: apply bench-side memory/RF behaviour, then sample 1ns after the falling edge
  task automatic tick();
    @(negedge clk);
    if (ld_hs_s) void'(ld_q.pop_front());
    cyc++;
    req_valid    = 1'b0;
    rf_st_data   = st_iss_s ? rf_model(iss_a_s, iss_o_s) : 64'd0;
    mem_rd_valid = (ld_q.size() > 0) && (cyc >= ld_start);
    mem_rd_data  = mem_rd_valid ? ld_q[0] : 64'd0;
    rf_ld_stall  = (cyc < 32) ? stall_mask[cyc] : 1'b0;
    mem_wr_ready = (cyc < 32) ? !wrblk_mask[cyc] : 1'b1;
    #1;
    ld_hs_s  = mem_rd_valid && mem_rd_ready;
    st_iss_s = (rf_st_en != 8'd0);
    iss_a_s  = rf_st_addr;
    iss_o_s  = rf_st_off;
  endtask

  task automatic send_req(input bit st, input logic [4:0] a, input logic [7:0] o,
                          input logic [8:0] n, input logic [7:0] be);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_vreg = a; req_off = o;
    req_beats = n; req_be = be;
    mem_rd_valid = 1'b0; rf_ld_stall = 1'b0; mem_wr_ready = 1'b1; rf_st_data = 64'd0;
    ld_hs_s = 1'b0; st_iss_s = 1'b0;
    cyc = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_at_request: got %b want 1", req_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, done, mem_rd_ready, mem_wr_valid, rf_ld_en, rf_st_en} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b done=%b rd_rdy=%b wr_v=%b ld_en=%h st_en=%h want all 0",
               req_ready, done, mem_rd_ready, mem_wr_valid, rf_ld_en, rf_st_en);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_wr_valid !== 1'b0 || perf_ld_stall !== 32'd0 || perf_st_stall !== 32'd0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b wr_v=%b perf=%0d/%0d want rdy=1 wr_v=0 perf=0/0",
               req_ready, mem_wr_valid, perf_ld_stall, perf_st_stall);
    end
  endtask

  task automatic test_load(input bit stall);
    beat_t       exp_q[$];
    beat_t       e;
    logic [4:0]  a = 5'd3;
    logic [7:0]  o = 8'd0;
    logic [63:0] d;
    int          c = 2;
    int          done_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      d = {16{4'(i + 1)}};
      ld_q.push_back(d);
      if (stall && c == 2) c = 4;
      e.a = a; e.o = o; e.d = d; e.last = (i == 3); e.cyc = c;
      exp_q.push_back(e);
      adv(a, o);
      c++;
    end
    ld_start   = 2;
    stall_mask = stall ? 32'h0000_000C : 32'd0;
    send_req(1'b0, 5'd3, 8'd0, 9'd4, 8'hFF);
    for (int k = 0; k < 30 && done_cyc < 0; k++) begin
      tick();
      if (stall && (cyc == 2 || cyc == 3)) begin
        checks++;
        if (mem_rd_ready !== 1'b0 || rf_ld_en !== 8'h00) begin
          failures++;
          $display("FAIL load_stall_cycle%0d: got rd_rdy=%b ld_en=%h want 0/00", cyc, mem_rd_ready, rf_ld_en);
        end
      end
      if (rf_ld_en !== 8'h00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL load_extra_beat: got ld_en=%h at cycle %0d want no beat", rf_ld_en, cyc);
        end else begin
          e = exp_q.pop_front();
          if (rf_ld_en !== 8'hFF || rf_ld_addr !== e.a || rf_ld_off !== e.o || rf_ld_data !== e.d || cyc != e.cyc) begin
            failures++;
            $display("FAIL load_beat: got en=%h reg=%0d off=%0d data=%h cyc=%0d want en=ff reg=%0d off=%0d data=%h cyc=%0d",
                     rf_ld_en, rf_ld_addr, rf_ld_off, rf_ld_data, cyc, e.a, e.o, e.d, e.cyc);
          end
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("FAIL load_ready_in_fin: got %b want 0", req_ready);
        end
      end
    end
    checks++;
    if (done_cyc != (stall ? 8 : 6) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL load_done: got done cycle %0d with %0d beats missing want cycle %0d with 0 missing",
               done_cyc, exp_q.size(), stall ? 8 : 6);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL load_ready_after_done: got rdy=%b done=%b want 1/0", req_ready, done);
    end
    stall_mask = 32'd0;
  endtask

  task automatic test_store(input logic [4:0] a0, input logic [7:0] o0, input int n,
                            input logic [7:0] be, input logic [31:0] blk,
                            input int exp_early, input int exp_done);
    beat_t      iss_q[$];
    beat_t      wr_q[$];
    beat_t      e;
    logic [4:0] a = a0;
    logic [7:0] o = o0;
    int         first_v = -1, last_hs = -1, done_cyc = -1, early = 0;
    for (int i = 0; i < n; i++) begin
      e.a = a; e.o = o; e.d = rf_model(a, o); e.last = (i == n - 1); e.cyc = 0;
      iss_q.push_back(e);
      wr_q.push_back(e);
      adv(a, o);
    end
    wrblk_mask = blk;
    send_req(1'b1, a0, o0, 9'(n), be);
    for (int k = 0; k < 60 && done_cyc < 0; k++) begin
      tick();
      if (rf_st_en !== 8'h00) begin
        checks++;
        if (last_hs < 0) early++;
        if (iss_q.size() == 0) begin
          failures++;
          $display("FAIL store_extra_issue: got st_en=%h at cycle %0d want none", rf_st_en, cyc);
        end else begin
          e = iss_q.pop_front();
          if (rf_st_en !== be || rf_st_addr !== e.a || rf_st_off !== e.o) begin
            failures++;
            $display("FAIL store_issue: got en=%h reg=%0d off=%0d want en=%h reg=%0d off=%0d",
                     rf_st_en, rf_st_addr, rf_st_off, be, e.a, e.o);
          end
        end
      end
      if (mem_wr_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (mem_wr_ready) begin
          checks++;
          last_hs = cyc;
          if (wr_q.size() == 0) begin
            failures++;
            $display("FAIL store_extra_write: got data=%h at cycle %0d want none", mem_wr_data, cyc);
          end else begin
            e = wr_q.pop_front();
            if (mem_wr_data !== e.d || mem_wr_be !== be || mem_wr_last !== e.last) begin
              failures++;
              $display("FAIL store_write: got data=%h be=%h last=%b want data=%h be=%h last=%b",
                       mem_wr_data, mem_wr_be, mem_wr_last, e.d, be, e.last);
            end
          end
        end
      end
      if (done === 1'b1) done_cyc = cyc;
    end
    checks++;
    if (first_v != 3 || done_cyc != exp_done || done_cyc != last_hs + 1 || early != exp_early ||
        iss_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL store_timing: got first_valid=%0d done=%0d last_hs=%0d early_issues=%0d left=%0d/%0d want 3 %0d %0d %0d 0/0",
               first_v, done_cyc, last_hs, early, iss_q.size(), wr_q.size(), exp_done, exp_done - 1, exp_early);
    end
    wrblk_mask = 32'd0;
    tick();
  endtask

  task automatic test_perf(input int exp_ld, input int exp_st);
    int want_ld = 0, want_st = 0;
`ifdef VEC_LDST_STALL_CNT_EN
    want_ld = exp_ld;
    want_st = exp_st;
`else
    if (exp_ld + exp_st < 0) want_ld = 1;
`endif
    checks++;
    if (perf_ld_stall !== 32'(want_ld) || perf_st_stall !== 32'(want_st)) begin
      failures++;
      $display("FAIL perf_counters: got ld=%0d st=%0d want ld=%0d st=%0d",
               perf_ld_stall, perf_st_stall, want_ld, want_st);
    end
  endtask

  task automatic test_zero_beats();
    ld_q.push_back(64'hDEAD_BEEF_0000_0001);
    ld_start = 1;
    send_req(1'b0, 5'd7, 8'd0, 9'd0, 8'hFF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (rf_ld_en !== 8'h00 || mem_rd_ready !== 1'b0 || done !== (cyc == 1) || req_ready !== (cyc >= 2)) begin
        failures++;
        $display("FAIL zero_beats_cycle%0d: got ld_en=%h rd_rdy=%b done=%b rdy=%b want 00 0 %b %b",
                 cyc, rf_ld_en, mem_rd_ready, done, req_ready, cyc == 1, cyc >= 2);
      end
    end
    ld_q.delete();
    ld_hs_s = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    wrblk_mask = 32'hFFFF_FFFF;
    send_req(1'b1, 5'd10, 8'd0, 9'd4, 8'hFF);
    while (cyc < 4) tick();
    checks++;
    if (mem_wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_store_buffered: got wr_v=%b want 1", mem_wr_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, done, mem_rd_ready, mem_wr_valid, mem_wr_last, rf_ld_en, rf_st_en, mem_wr_be} !== 29'd0 ||
        {mem_wr_data, rf_ld_data, rf_st_addr, rf_st_off} !== 141'd0) begin
      failures++;
      $display("FAIL reset_mid_store: got rdy=%b done=%b wr_v=%b st_en=%h wr_be=%h wr_data=%h st_reg=%0d want all 0",
               req_ready, done, mem_wr_valid, rf_st_en, mem_wr_be, mem_wr_data, rf_st_addr);
    end
    wrblk_mask = 32'd0;
    st_iss_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_wr_valid !== 1'b0 || perf_ld_stall !== 32'd0 || perf_st_stall !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_store_release: got rdy=%b wr_v=%b perf=%0d/%0d want 1 0 0/0",
               req_ready, mem_wr_valid, perf_ld_stall, perf_st_stall);
    end
    test_store(5'd20, 8'd1, 1, 8'h3C, 32'd0, 1, 4);
  endtask

  initial begin
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_store(5'd31, 8'd1, 2, 8'h0F, 32'd0, 2, 5);
    test_store(5'd5, 8'd0, 6, 8'hF0, 32'h0000_01F8, 3, 15);
    test_perf(2, 6);
    test_zero_beats();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
